// File: rtl/rpsc_annunciator.sv
// rtl/rpsc_annunciator.sv - first-out fault annunciator for the RPSC interlock card
// Eight lock-in alarm channels with flash/steady lamps, horn, ack/reset and first-out capture.
module rpsc_annunciator #(
  parameter int FLASH_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fault_in,
  input  logic       ack,
  input  logic       rst_btn,
  input  logic       lamp_test,
  output logic [7:0] lamp,
  output logic       horn,
  output logic [7:0] first_out,
  output logic       first_valid,
  output logic       trip
);

  localparam int CW = $clog2(FLASH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(FLASH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALERT   = 2'd1,
    ST_ACKED   = 2'd2,
    ST_CLEARED = 2'd3
  } state_e;

  // Synchronizers; button chains carry a third stage for rising-edge detection.
  logic [7:0] fault_s1_q, fault_s2_q;
  logic [2:0] ack_sync_q, rst_sync_q;
  logic [1:0] lt_sync_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fast_q, fast_d;
  logic          slow_q, slow_d;

  state_e        state_q [8];
  state_e        state_d [8];
  logic [7:0]    entered_q, entered_d;

  logic [7:0]    lamp_q, lamp_d;
  logic          horn_q, horn_d;
  logic [7:0]    first_out_q, first_out_d;
  logic          first_valid_q, first_valid_d;
  logic          trip_q, trip_d;

  logic          ack_p, rst_p;
  logic          all_idle, any_alert;

  assign ack_p = ack_sync_q[1] & ~ack_sync_q[2];
  assign rst_p = rst_sync_q[1] & ~rst_sync_q[2];

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    fast_d = fast_q;
    slow_d = slow_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      fast_d = ~fast_q;
      // Slow toggles on the falling fast toggle, giving twice the half period.
      if (fast_q) slow_d = ~slow_q;
    end
  end

  always_comb begin
    entered_d = '0;
    for (int i = 0; i < 8; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (fault_s2_q[i]) begin
            state_d[i]   = ST_ALERT;
            entered_d[i] = 1'b1;
          end
        end
        ST_ALERT: begin
          if (ack_p) state_d[i] = fault_s2_q[i] ? ST_ACKED : ST_CLEARED;
        end
        ST_ACKED: begin
          if (!fault_s2_q[i]) state_d[i] = ST_CLEARED;
        end
        ST_CLEARED: begin
          // A returning fault outranks an operator reset in the same cycle.
          if (fault_s2_q[i])  state_d[i] = ST_ALERT;
          else if (rst_p)     state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lamp_d    = '0;
    all_idle  = 1'b1;
    any_alert = 1'b0;
    for (int i = 0; i < 8; i++) begin
      case (state_q[i])
        ST_ALERT: begin
          lamp_d[i] = fast_q;
          any_alert = 1'b1;
          all_idle  = 1'b0;
        end
        ST_ACKED: begin
          lamp_d[i] = 1'b1;
          all_idle  = 1'b0;
        end
        ST_CLEARED: begin
          lamp_d[i] = slow_q;
          all_idle  = 1'b0;
        end
        default: lamp_d[i] = 1'b0;
      endcase
    end
    if (lt_sync_q[1]) lamp_d = 8'hFF;
    horn_d = any_alert;
    trip_d = ~all_idle;

    first_out_d   = first_out_q;
    first_valid_d = first_valid_q;
    if (all_idle) begin
      first_out_d   = '0;
      first_valid_d = 1'b0;
    end else if (!first_valid_q && (entered_q != 8'd0)) begin
      first_out_d   = entered_q & (~entered_q + 8'd1);
      first_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_s1_q    <= '0;
      fault_s2_q    <= '0;
      ack_sync_q    <= '0;
      rst_sync_q    <= '0;
      lt_sync_q     <= '0;
      cnt_q         <= '0;
      fast_q        <= 1'b0;
      slow_q        <= 1'b0;
      for (int i = 0; i < 8; i++) state_q[i] <= ST_IDLE;
      entered_q     <= '0;
      lamp_q        <= '0;
      horn_q        <= 1'b0;
      first_out_q   <= '0;
      first_valid_q <= 1'b0;
      trip_q        <= 1'b0;
    end else begin
      fault_s1_q    <= fault_in;
      fault_s2_q    <= fault_s1_q;
      ack_sync_q    <= {ack_sync_q[1:0], ack};
      rst_sync_q    <= {rst_sync_q[1:0], rst_btn};
      lt_sync_q     <= {lt_sync_q[0], lamp_test};
      cnt_q         <= cnt_d;
      fast_q        <= fast_d;
      slow_q        <= slow_d;
      for (int i = 0; i < 8; i++) state_q[i] <= state_d[i];
      entered_q     <= entered_d;
      lamp_q        <= lamp_d;
      horn_q        <= horn_d;
      first_out_q   <= first_out_d;
      first_valid_q <= first_valid_d;
      trip_q        <= trip_d;
    end
  end

  assign lamp        = lamp_q;
  assign horn        = horn_q;
  assign first_out   = first_out_q;
  assign first_valid = first_valid_q;
  assign trip        = trip_q;

endmodule

// File: tb/tb_rpsc_annunciator.sv
// tb/tb_rpsc_annunciator.sv - scoreboard bench for rpsc_annunciator
// Reference model predicts each cycle's outputs from input history; a monitor pops and compares.
module tb_rpsc_annunciator;

  localparam int D = 4;
  localparam int M_IDLE = 0, M_ALERT = 1, M_ACKED = 2, M_CLEARED = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] fault_in = 8'h00;
  logic       ack = 1'b0;
  logic       rst_btn = 1'b0;
  logic       lamp_test = 1'b0;
  logic [7:0] lamp;
  logic       horn;
  logic [7:0] first_out;
  logic       first_valid;
  logic       trip;

  rpsc_annunciator #(.FLASH_DIV(D)) dut (
    .clk(clk), .reset(reset), .fault_in(fault_in), .ack(ack), .rst_btn(rst_btn),
    .lamp_test(lamp_test), .lamp(lamp), .horn(horn), .first_out(first_out),
    .first_valid(first_valid), .trip(trip)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] lamp;
    logic       horn;
    logic [7:0] fo;
    logic       fv;
    logic       trip;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  // Reference model state: channel states, edges since reset, capture, input history.
  int         m_st [8];
  int         m_n;
  logic [7:0] m_cap;
  logic [7:0] fh [3];
  logic       ah [3], rh [3], lh [3];
  exp_t       e_new;
  logic       m_fast, m_slow, m_any_busy, ap, rp;
  logic [7:0] f_now, entered;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_st[i] = M_IDLE;
    m_n   = 0;
    m_cap = 8'h00;
    for (int k = 0; k < 3; k++) begin
      fh[k] = 8'h00; ah[k] = 1'b0; rh[k] = 1'b0; lh[k] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      model_reset();
    end else begin
      m_fast = ((m_n / D) % 2) == 1;
      m_slow = ((m_n / (2 * D)) % 2) == 1;
      e_new  = '0;
      for (int ch = 0; ch < 8; ch++) begin
        if (m_st[ch] == M_ALERT)   e_new.lamp[ch] = m_fast;
        if (m_st[ch] == M_ACKED)   e_new.lamp[ch] = 1'b1;
        if (m_st[ch] == M_CLEARED) e_new.lamp[ch] = m_slow;
        if (m_st[ch] == M_ALERT)   e_new.horn = 1'b1;
        if (m_st[ch] != M_IDLE)    e_new.trip = 1'b1;
      end
      if (lh[1]) e_new.lamp = 8'hFF;
      e_new.fo = m_cap;
      e_new.fv = (m_cap != 8'h00);
      exp_q.push_back(e_new);

      f_now   = fh[1];
      ap      = ah[1] & ~ah[2];
      rp      = rh[1] & ~rh[2];
      entered = 8'h00;
      for (int ch = 0; ch < 8; ch++) begin
        case (m_st[ch])
          M_IDLE:    if (f_now[ch]) begin m_st[ch] = M_ALERT; entered[ch] = 1'b1; end
          M_ALERT:   if (ap) m_st[ch] = f_now[ch] ? M_ACKED : M_CLEARED;
          M_ACKED:   if (!f_now[ch]) m_st[ch] = M_CLEARED;
          default:   if (f_now[ch]) m_st[ch] = M_ALERT; else if (rp) m_st[ch] = M_IDLE;
        endcase
      end
      m_any_busy = 1'b0;
      for (int ch = 0; ch < 8; ch++) if (m_st[ch] != M_IDLE) m_any_busy = 1'b1;
      if (!m_any_busy) m_cap = 8'h00;
      else if (m_cap == 8'h00) begin
        for (int ch = 7; ch >= 0; ch--) if (entered[ch]) m_cap = 8'h01 << ch;
      end

      fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = fault_in;
      ah[2] = ah[1]; ah[1] = ah[0]; ah[0] = ack;
      rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = rst_btn;
      lh[2] = lh[1]; lh[1] = lh[0]; lh[0] = lamp_test;
      m_n++;
    end
  end

  exp_t e_chk;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e_chk = exp_q.pop_front();
      chk("lamp", lamp, e_chk.lamp);
      chk("horn", {7'd0, horn}, {7'd0, e_chk.horn});
      chk("first_out", first_out, e_chk.fo);
      chk("first_valid", {7'd0, first_valid}, {7'd0, e_chk.fv});
      chk("trip", {7'd0, trip}, {7'd0, e_chk.trip});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_ack(input int hold);
    ack = 1'b1; cyc(hold); ack = 1'b0; cyc(4);
  endtask

  task automatic press_rst(input int hold);
    rst_btn = 1'b1; cyc(hold); rst_btn = 1'b0; cyc(4);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lamp"}, lamp, 8'h00);
    chk({tag, "_horn"}, {7'd0, horn}, 8'h00);
    chk({tag, "_first_out"}, first_out, 8'h00);
    chk({tag, "_first_valid"}, {7'd0, first_valid}, 8'h00);
    chk({tag, "_trip"}, {7'd0, trip}, 8'h00);
  endtask

  int hold [8];
  int ack_cnt, rst_cnt;

  initial begin
    cyc(3);
    chk_all_zero("reset");
    #2 reset = 1'b1;
    cyc(100);

    // Single fault: check the k+2 / k+3 latency directly as well as via the model.
    fault_in = 8'h04;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("lat_horn_k2", {7'd0, horn}, 8'h00);
    @(posedge clk); #1;
    chk("lat_horn_k3", {7'd0, horn}, 8'h01);
    chk("lat_trip_k3", {7'd0, trip}, 8'h01);
    chk("lat_first_out_k3", first_out, 8'h04);
    chk("lat_first_valid_k3", {7'd0, first_valid}, 8'h01);
    @(negedge clk);
    cyc(20);
    press_ack(3);
    cyc(12);
    fault_in = 8'h00;
    cyc(24);
    press_rst(2);
    cyc(6);
    chk("after_rst_trip", {7'd0, trip}, 8'h00);

    // Simultaneous trips, then a later one that must not move the capture.
    fault_in = 8'h30;
    cyc(10);
    fault_in = 8'h31;
    cyc(10);
    chk("first_out_simul", first_out, 8'h10);
    press_ack(2);
    fault_in = 8'h00;
    cyc(6);
    press_rst(2);
    cyc(6);

    // Locked-in short fault: reset ignored while ALERT.
    fault_in = 8'h02;
    cyc(5);
    fault_in = 8'h00;
    cyc(10);
    press_rst(2);
    cyc(4);
    chk("lockin_horn", {7'd0, horn}, 8'h01);
    press_ack(2);
    cyc(6);
    press_rst(2);
    cyc(6);

    // Mixed states with lamp test.
    fault_in = 8'h81;
    cyc(6);
    press_ack(2);
    fault_in = 8'h80;
    cyc(6);
    fault_in = 8'h84;
    cyc(6);
    lamp_test = 1'b1;
    cyc(12);
    lamp_test = 1'b0;
    cyc(6);

    // Async reset while ALERT, faults still active across release.
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    cyc(3);
    #2 reset = 1'b1;
    cyc(20);

    for (int b = 0; b < 8; b++) hold[b] = 0;
    ack_cnt = 0;
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        if (hold[b] == 0) begin
          if ($urandom_range(0, 2) == 0) fault_in[b] = ~fault_in[b];
          hold[b] = $urandom_range(2, 40);
        end else begin
          hold[b]--;
        end
      end
      if (ack_cnt > 0) ack_cnt--;
      else if (ack) ack = 1'b0;
      else if ($urandom_range(0, 11) == 0) begin ack = 1'b1; ack_cnt = $urandom_range(0, 3); end
      if (rst_cnt > 0) rst_cnt--;
      else if (rst_btn) rst_btn = 1'b0;
      else if ($urandom_range(0, 9) == 0) begin rst_btn = 1'b1; rst_cnt = $urandom_range(0, 3); end
      if ($urandom_range(0, 49) == 0) lamp_test = ~lamp_test;
    end

    fault_in  = 8'h00;
    ack       = 1'b0;
    rst_btn   = 1'b0;
    lamp_test = 1'b0;
    cyc(30);
    #1 chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpsc_annunciator.md
# rpsc_annunciator

First-out fault annunciator sitting directly downstream of the RPSC interlock card. Consumes the eight card fault outputs (Emergency, Card POS, Air Grid, Air Anode, Water Heat Exchanger, Water Anode, Door PAMP, GR SW) and runs a per-channel lock-in alarm sequence with flash/steady lamps, horn, acknowledge, and reset. It also records which fault tripped first, for the operator panel and the trip logic.

## Interface
- FLASH_DIV, 25_000_000: clk cycles per fast-flash half period, ≥2.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state when 0.
- fault_in  in  8  active-high fault levels from the card OUT pins; bits 0..7 = FF1..FF8.
- ack  in  1  operator acknowledge pushbutton, level, asynchronous.
- rst_btn  in  1  operator alarm-reset pushbutton, level, asynchronous.
- lamp_test  in  1  lamp test, level, asynchronous.
- lamp  out  8  per-channel lamp drive, 1 = lit.
- horn  out  1  audible alarm.
- first_out  out  8  one-hot first-tripped channel, 0 when none.
- first_valid  out  1  first_out holds a capture.
- trip  out  1  any channel not in IDLE.

## Operation
- Input synchronization:
  - fault_in, ack, rst_btn and lamp_test each pass through a 2-flop synchronizer; the sync flops reset to 0.
  - ack and rst_btn drive a third flop for rising-edge detection: one-cycle pulses ack_p and rst_p.
- Per-channel FSM, 8 independent copies. f = synchronized fault bit.
  - IDLE: f=1 → ALERT.
  - ALERT: ack_p → ACKED if f=1, else CLEARED. Fault dropping alone does not leave ALERT (lock-in). rst_p is ignored.
  - ACKED: f=0 → CLEARED. ack_p and rst_p are ignored.
  - CLEARED: f=1 → ALERT, and this takes priority over rst_p in the same cycle. Otherwise rst_p → IDLE.
- Flash generator:
  - Free-running counter 0..FLASH_DIV-1. fast toggles at each wrap; slow toggles on every second fast toggle.
  - Counter, fast and slow all reset to 0.
- Lamp decode per channel:
  - IDLE: off.
  - ALERT: fast.
  - ACKED: on.
  - CLEARED: slow (ringback).
  - lamp_test=1 forces lamp=8'hFF; no effect on FSM, horn or first-out.
- horn = 1 when any channel is in ALERT.
- First-out capture:
  - When first_valid=0 and one or more channels go IDLE→ALERT in the same cycle, capture the lowest-index such channel one-hot and set first_valid.
  - Later trips do not change the capture.
  - first_valid and first_out clear in the cycle all eight FSMs are IDLE.
- trip = OR over channels of (state ≠ IDLE).

## Timing
- Reset values: lamp=0, horn=0, first_out=0, first_valid=0, trip=0, all FSMs IDLE.
- Outputs lamp, horn, first_out, first_valid and trip are registered from FSM/flash state, one cycle after the FSM.
- fault_in rising, sampled at edge k:
  - Synchronizer stages at k and k+1.
  - FSM reaches ALERT at k+2.
  - horn, trip, first_out and lamp update at k+3.
- ack/rst_btn rising, sampled at edge k: pulse is valid in the cycle after k+1, the FSM acts at k+2, and outputs change at k+3.
- A held button produces exactly one pulse; the button must go low for ≥1 synchronized cycle before the next pulse.
- Fault pulses narrower than one clk may be missed; upstream holds faults ≥2 cycles.
- Simultaneous ack_p and rst_p: each FSM applies the rule for its own state; no channel moves two states in one cycle.
- reset asserted mid-sequence: immediate return to reset values. After release, still-active faults re-alarm with full sync latency.

## Test plan
- Reset release with fault_in=0 → all outputs 0 for 100 cycles.
- FLASH_DIV=4; fault_in=8'h04 at edge 10 → horn=1, trip=1, first_out=8'h04, first_valid=1 at edge 13; lamp[2] toggles every 4 cycles.
- fault_in=8'h30 in the same cycle, then 8'h31 later → first_out=8'h10; channel 0 alarms but first_out is unchanged.
- Ack with fault held → lamp[2] steady 1, horn=0. Drop fault → lamp[2] flashes at 8-cycle half period. rst_btn → lamp=0, trip=0, first_valid=0.
- Fault pulse of 5 cycles, no ack → channel stays ALERT. rst_btn is ignored. Ack → CLEARED. rst_btn → IDLE.
- lamp_test=1 during mixed states → lamp=8'hFF, horn unchanged. reset pulled low in ALERT → all outputs 0 asynchronously.
